// File: rtl/rr_mux_arbiter4.sv
// rr_mux_arbiter4
//   Round-robin arbiter that hands one shared 4:1 32-bit datapath mux to one
//   of four requesters at a time. Ownership lasts until the owner strobes
//   done, drops its request, or has held the path for MAX_HOLD cycles (forced
//   preemption). On a release the arbiter re-arbitrates in the same edge, so
//   back-to-back owners see no idle bubble.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   iReq     : per-requester request level
//   iDone    : per-requester release strobe (only the owner's bit matters)
//   oGnt     : registered one-hot grant, zero when idle
//   oSel     : registered mux select, index of current/last owner
//   oBusy    : high while a grant is active
//   oPreempt : one-cycle pulse after a release forced by the hold limit
module rr_mux_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] iReq,
    input  logic [3:0] iDone,
    output logic [3:0] oGnt,
    output logic [1:0] oSel,
    output logic       oBusy,
    output logic       oPreempt
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    localparam int HOLD_LAST_INT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_LAST_INT[CNT_W-1:0];
    // With preemption disabled the counter just parks at its maximum.
    localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HOLD_LAST;

    state_t           state_reg, state_next;
    logic [3:0]       gnt_reg, gnt_next;
    logic [1:0]       sel_reg, sel_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             preempt_reg, preempt_next;

    logic       owner_done, owner_drop, hold_expired, release_now;
    logic [1:0] scan_start;
    logic [3:0] cand;
    logic [3:0] hit;
    logic       win_found;
    logic [1:0] win_off, win_idx;

    // While granted, sel_reg is the owner index.
    assign owner_done   = iDone[sel_reg];
    assign owner_drop   = ~iReq[sel_reg];
    assign hold_expired = (MAX_HOLD != 0) && (cnt_reg == HOLD_LAST);
    assign release_now  = (state_reg == ST_GRANT) && (owner_done || owner_drop || hold_expired);

    // After a release scanning starts just past the owner, which leaves the
    // owner itself as the last candidate; it stays eligible only if it still
    // requests and has not signalled done.
    assign scan_start = (state_reg == ST_GRANT) ? sel_reg + 2'd1 : ptr_reg;

    always_comb begin
        cand = iReq;
        if (state_reg == ST_GRANT && owner_done) begin
            cand[sel_reg] = 1'b0;
        end
    end

    // hit[k] is the candidate k positions after scan_start.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [1:0] OFF = 2'(gi);
            assign hit[gi] = cand[scan_start + OFF];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_off   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                win_found = 1'b1;
                win_off   = 2'(i);
            end
        end
    end

    assign win_idx = scan_start + win_off;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= 4'b0000;
            sel_reg     <= 2'd0;
            ptr_reg     <= 2'd0;
            cnt_reg     <= '0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            sel_reg     <= sel_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            preempt_reg <= preempt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (win_found) state_next = ST_GRANT;
            ST_GRANT: if (release_now && !win_found) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered-output next values
    always_comb begin
        gnt_next     = gnt_reg;
        sel_next     = sel_reg;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;
        preempt_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_next = 4'b0001 << win_idx;
                    sel_next = win_idx;
                    cnt_next = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_next     = sel_reg + 2'd1;
                    preempt_next = hold_expired && !owner_done && !owner_drop;
                    cnt_next     = '0;
                    if (win_found) begin
                        gnt_next = 4'b0001 << win_idx;
                        sel_next = win_idx;
                    end else begin
                        // sel_reg is kept so the shared mux output stays stable.
                        gnt_next = 4'b0000;
                    end
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                gnt_next = 4'b0000;
            end
        endcase
    end

    assign oGnt     = gnt_reg;
    assign oSel     = sel_reg;
    assign oBusy    = (state_reg == ST_GRANT);
    assign oPreempt = preempt_reg;

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// tb_rr_mux_arbiter4
//   Directed bench for rr_mux_arbiter4 built with a hold limit of 4. A
//   behavioural model tracks the owner as an integer (-1 when idle) and the
//   number of cycles it has owned the path; every cycle the DUT outputs are
//   compared against it, and literal expectations at key points pin both the
//   DUT and the model.
module tb_rr_mux_arbiter4;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] iReq = 4'b1111;
    logic [3:0] iDone = 4'b0000;
    logic [3:0] oGnt;
    logic [1:0] oSel;
    logic       oBusy;
    logic       oPreempt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state
    int   m_owner = -1;
    int   m_sel = 0;
    int   m_ptr = 0;
    int   m_held = 0;
    logic m_preempt = 1'b0;

    rr_mux_arbiter4 #(.MAX_HOLD(HOLD), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iReq     (iReq),
        .iDone    (iDone),
        .oGnt     (oGnt),
        .oSel     (oSel),
        .oBusy    (oBusy),
        .oPreempt (oPreempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First requester set in v, looking at start, start+1, ... mod 4.
    function automatic int scan(input int start, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] r;
        r = 4'b0000;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    // Model update on each edge, then compare just after the edge.
    always @(posedge clk) begin
        int         w;
        int         g;
        logic       done_b, drop_b, expire_b;
        logic [3:0] elig;
        if (!rst_n) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_preempt = 1'b0;
        end else if (m_owner < 0) begin
            m_preempt = 1'b0;
            w = scan(m_ptr, iReq);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_held = 1;
            end
        end else begin
            g        = m_owner;
            done_b   = iDone[g];
            drop_b   = !iReq[g];
            expire_b = (m_held == HOLD);
            m_preempt = 1'b0;
            if (done_b || drop_b || expire_b) begin
                m_ptr = (g + 1) % 4;
                elig = iReq;
                if (done_b) elig[g] = 1'b0;
                m_preempt = expire_b && !done_b && !drop_b;
                w = scan((g + 1) % 4, elig);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_held = 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_held++;
            end
        end
        #1;
        cyc++;
        $display("cyc=%0d rst_n=%b req=%b done=%b gnt=%b sel=%0d busy=%b pre=%b",
                 cyc, rst_n, iReq, iDone, oGnt, oSel, oBusy, oPreempt);
        check("gnt", 32'(oGnt), 32'(onehot(m_owner)));
        check("sel", 32'(oSel), 32'(m_sel));
        check("busy", 32'(oBusy), 32'(m_owner >= 0));
        check("preempt", 32'(oPreempt), 32'(m_preempt));
        check("gnt_onehot0", 32'($onehot0(oGnt)), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // 1. Reset with all requesting, then first grant and done handoff
        tick(); tick();
        check("rst_gnt", 32'(oGnt), 32'h0);
        check("rst_sel", 32'(oSel), 32'h0);
        check("rst_busy", 32'(oBusy), 32'h0);
        check("rst_pre", 32'(oPreempt), 32'h0);
        rst_n = 1'b1;
        tick();
        check("t1_gnt0", 32'(oGnt), 32'h1);
        check("t1_busy", 32'(oBusy), 32'h1);
        check("t1_model_owner", 32'(m_owner), 32'd0);
        iDone = 4'b0001;
        tick();
        check("t1_gnt1", 32'(oGnt), 32'h2);
        check("t1_sel1", 32'(oSel), 32'h1);
        check("t1_nobubble", 32'(oBusy), 32'h1);

        // 2. Rotation 1 -> 2 -> 3 -> 0 -> 1
        iDone = 4'b0010; tick();
        check("t2_gnt2", 32'(oGnt), 32'h4);
        check("t2_sel2", 32'(oSel), 32'h2);
        iDone = 4'b0100; tick();
        check("t2_gnt3", 32'(oGnt), 32'h8);
        check("t2_sel3", 32'(oSel), 32'h3);
        iDone = 4'b1000; tick();
        check("t2_gnt0", 32'(oGnt), 32'h1);
        check("t2_sel0", 32'(oSel), 32'h0);
        iDone = 4'b0001; tick();
        check("t2_gnt1b", 32'(oGnt), 32'h2);

        // 5. Non-owner done is ignored
        iDone = 4'b0100; tick();
        check("t5_gnt", 32'(oGnt), 32'h2);
        check("t5_model_held", 32'(m_held), 32'd2);
        iDone = 4'b0000;

        // 4. Owner 1 drops -> 2 wins, then 2 drops with nothing else -> idle
        iReq = 4'b0100; tick();
        check("t4_gnt2", 32'(oGnt), 32'h4);
        check("t4_pre", 32'(oPreempt), 32'h0);
        iReq = 4'b0000; tick();
        check("t4_idle_gnt", 32'(oGnt), 32'h0);
        check("t4_idle_busy", 32'(oBusy), 32'h0);
        check("t4_idle_sel", 32'(oSel), 32'h2);
        tick();
        check("t4_idle_sel2", 32'(oSel), 32'h2);
        iReq = 4'b1001; tick();
        check("t4_ptr3_gnt", 32'(oGnt), 32'h8);
        check("t4_ptr3_sel", 32'(oSel), 32'h3);

        // 6. Reset mid-grant, then ptr back at 0
        iReq = 4'b1010;
        rst_n = 1'b0; tick();
        check("t6_gnt", 32'(oGnt), 32'h0);
        check("t6_sel", 32'(oSel), 32'h0);
        check("t6_busy", 32'(oBusy), 32'h0);
        check("t6_pre", 32'(oPreempt), 32'h0);
        rst_n = 1'b1; tick();
        check("t6_owner1", 32'(oGnt), 32'h2);

        // 3. Preemption with hold limit 4
        rst_n = 1'b0; iReq = 4'b0101; tick();
        rst_n = 1'b1; tick();
        check("t3_gnt0_c1", 32'(oGnt), 32'h1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t3_hold0", 32'(oGnt), 32'h1);
            check("t3_hold0_pre", 32'(oPreempt), 32'h0);
        end
        tick();
        check("t3_gnt2", 32'(oGnt), 32'h4);
        check("t3_pre1", 32'(oPreempt), 32'h1);
        check("t3_model_pre", 32'(m_preempt), 32'h1);
        tick();
        check("t3_pre_pulse", 32'(oPreempt), 32'h0);
        tick(); tick(); tick();
        check("t3_back0", 32'(oGnt), 32'h1);
        check("t3_pre2", 32'(oPreempt), 32'h1);

        // Done coinciding with expiry is a normal release
        tick(); tick(); tick();
        iDone = 4'b0001; tick();
        check("sim_gnt2", 32'(oGnt), 32'h4);
        check("sim_nopre", 32'(oPreempt), 32'h0);
        iDone = 4'b0000;

        // Lone requester preempted re-wins itself, still pulses preempt
        iReq = 4'b0100;
        tick(); tick(); tick();
        tick();
        check("lone_gnt", 32'(oGnt), 32'h4);
        check("lone_pre", 32'(oPreempt), 32'h1);

        // Short mixed vector table, checked by the model only
        for (int i = 0; i < 40; i++) begin
            iReq  = 4'($urandom_range(0, 15));
            iDone = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick();
        end
        iReq = 4'b0000; iDone = 4'b0000;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
